// File: rtl/disp_pkg.sv
// disp_pkg: shared FSM type, sizes and segment constants for the display scan controller
package disp_pkg;
  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    COMMIT
  } state_t;
  localparam int BCD_W = 12;
  localparam int ITERS = 8;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  function automatic logic [3:0] dabble_adj(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction
endpackage

// File: rtl/seg7_enc.sv
// seg7_enc: BCD digit to active-low gfedcba segments; non-decimal codes stay dark
module seg7_enc import disp_pkg::*; (
  input  logic [3:0] i_digit,
  output logic [6:0] o_seg
);
  // Decimal lookup, anything above 9 falls through to blank
  always_comb begin
    o_seg = SEG_BLANK;
    case (i_digit)
      4'd0: o_seg = SEG_0;
      4'd1: o_seg = SEG_1;
      4'd2: o_seg = SEG_2;
      4'd3: o_seg = SEG_3;
      4'd4: o_seg = SEG_4;
      4'd5: o_seg = SEG_5;
      4'd6: o_seg = SEG_6;
      4'd7: o_seg = SEG_7;
      4'd8: o_seg = SEG_8;
      4'd9: o_seg = SEG_9;
      default: o_seg = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: binary-to-BCD converter feeding a 3-digit multiplexed 7-segment scanner
module disp_scan_ctrl import disp_pkg::*; #(
  parameter int SCAN_W = 6,
  parameter int VAL_W  = 8
) (
  input  logic             clk_pi,
  input  logic             rst_pi,
  input  logic [VAL_W-1:0] value_pi,
  input  logic             load_pi,
  input  logic             blank_en_pi,
  output logic             busy_po,
  output logic             done_po,
  output logic [2:0]       anode_po,
  output logic [6:0]       cathode_po
);
  state_t            r_state, w_state_nxt;
  logic [VAL_W-1:0]  r_bin;
  logic [BCD_W-1:0]  r_bcd, w_bcd_adj, r_shadow;
  logic [2:0]        r_iter;
  logic [SCAN_W-1:0] r_scan;
  logic [1:0]        r_idx;
  logic [3:0]        w_digit;
  logic [6:0]        w_seg;
  logic [2:0]        w_anode;
  logic              w_blank;
  logic [2:0]        r_anode;
  logic [6:0]        r_cathode;

  // State register
  always_ff @(posedge clk_pi) begin
    if (!rst_pi) r_state <= IDLE;
    else r_state <= w_state_nxt;
  end

  // Next state and status outputs: one capture cycle, eight dabble steps, one commit
  always_comb begin
    w_state_nxt = r_state;
    busy_po     = 1'b0;
    done_po     = 1'b0;
    case (r_state)
      IDLE:    w_state_nxt = load_pi ? CONVERT : IDLE;
      CONVERT: begin
        busy_po     = 1'b1;
        w_state_nxt = (r_iter == 3'(ITERS - 1)) ? COMMIT : CONVERT;
      end
      COMMIT:  begin
        busy_po     = 1'b1;
        done_po     = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Add-3 correction of every BCD nibble before the shift
  always_comb begin
    w_bcd_adj = {dabble_adj(r_bcd[11:8]), dabble_adj(r_bcd[7:4]), dabble_adj(r_bcd[3:0])};
  end

  // Conversion datapath; the shadow only moves on commit so the scan never sees partial BCD
  always_ff @(posedge clk_pi) begin
    if (!rst_pi) begin
      r_bin    <= '0;
      r_bcd    <= '0;
      r_iter   <= '0;
      r_shadow <= '0;
    end else if (r_state == IDLE && load_pi) begin
      r_bin  <= value_pi;
      r_bcd  <= '0;
      r_iter <= '0;
    end else if (r_state == CONVERT) begin
      {r_bcd, r_bin} <= {w_bcd_adj, r_bin} << 1;
      r_iter         <= r_iter + 3'd1;
    end else if (r_state == COMMIT) begin
      r_shadow <= r_bcd;
    end
  end

  // Free-running dwell counter; digit index steps units->tens->hundreds on each wrap
  always_ff @(posedge clk_pi) begin
    if (!rst_pi) begin
      r_scan <= '0;
      r_idx  <= 2'd0;
    end else begin
      r_scan <= r_scan + 1'b1;
      r_idx  <= (&r_scan) ? ((r_idx == 2'd2) ? 2'd0 : r_idx + 2'd1) : r_idx;
    end
  end

  // Digit select and leading-zero blanking for the current slot
  always_comb begin
    w_digit = (r_idx == 2'd2) ? r_shadow[11:8] : (r_idx == 2'd1) ? r_shadow[7:4] : r_shadow[3:0];
    w_anode = (r_idx == 2'd0) ? 3'b110 : (r_idx == 2'd1) ? 3'b101 : (r_idx == 2'd2) ? 3'b011 : 3'b111;
    w_blank = blank_en_pi && ((r_idx == 2'd2 && r_shadow[11:8] == 4'd0) ||
                              (r_idx == 2'd1 && r_shadow[11:4] == 8'd0));
  end

  seg7_enc u_seg (
    .i_digit(w_digit),
    .o_seg  (w_seg)
  );

  // Registered drive so anode and cathode change together one cycle after the index
  always_ff @(posedge clk_pi) begin
    if (!rst_pi) begin
      r_anode   <= 3'b111;
      r_cathode <= SEG_BLANK;
    end else begin
      r_anode   <= w_blank ? 3'b111 : w_anode;
      r_cathode <= w_blank ? SEG_BLANK : w_seg;
    end
  end

  assign anode_po   = r_anode;
  assign cathode_po = r_cathode;
endmodule

// File: tb/tb_disp_scan_ctrl.sv
// tb_disp_scan_ctrl: table-driven and randomized checks of the display scan controller
module tb_disp_scan_ctrl;
  localparam int DWELL = 64;

  logic       clk_pi = 1'b0;
  logic       rst_pi = 1'b0;
  logic       load_pi = 1'b0;
  logic       blank_en_pi = 1'b0;
  logic [7:0] value_pi = 8'd0;
  logic       busy_po, done_po;
  logic [2:0] anode_po;
  logic [6:0] cathode_po;

  int n_vec = 0;
  int n_err = 0;
  int n_done = 0;
  bit mon_en = 0;

  disp_scan_ctrl #(.SCAN_W(6), .VAL_W(8)) dut (
    .clk_pi     (clk_pi),
    .rst_pi     (rst_pi),
    .value_pi   (value_pi),
    .load_pi    (load_pi),
    .blank_en_pi(blank_en_pi),
    .busy_po    (busy_po),
    .done_po    (done_po),
    .anode_po   (anode_po),
    .cathode_po (cathode_po)
  );

  always #5 clk_pi = ~clk_pi;

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  function automatic int digit(int v, int s);
    return (s == 0) ? v % 10 : (s == 1) ? (v / 10) % 10 : v / 100;
  endfunction

  function automatic bit blanked(int v, int s, bit b);
    return b && ((s == 2 && v < 100) || (s == 1 && v < 10));
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: edges since reset, conversion phase, committed value as an integer
  int k = 0, p = -1, cap = 0, shadow = 0, out_idx = -1;
  bit bl;
  logic       exp_busy = 1'b0, exp_done = 1'b0;
  logic [2:0] exp_an = 3'b111;
  logic [6:0] exp_cat = 7'h7f;

  always @(posedge clk_pi) begin
    if (!rst_pi) begin
      k = 0; p = -1; shadow = 0; out_idx = -1;
      exp_an = 3'b111; exp_cat = 7'h7f;
    end else begin
      out_idx = (k / DWELL) % 3;
      bl = blanked(shadow, out_idx, blank_en_pi);
      exp_an = bl ? 3'b111 : 3'b111 ^ (3'b001 << out_idx);
      exp_cat = bl ? 7'h7f : seg_tab[digit(shadow, out_idx)];
      if (p == 8) begin shadow = cap; p = -1; end
      else if (p >= 0) p++;
      else if (load_pi) begin cap = int'(value_pi); p = 0; end
      k++;
    end
    exp_busy = (p >= 0);
    exp_done = (p == 8);
  end

  always @(negedge clk_pi) begin
    if (mon_en) begin
      check("mon_busy", busy_po, exp_busy);
      check("mon_done", done_po, exp_done);
      check("mon_anode", anode_po, exp_an);
      check("mon_cathode", cathode_po, exp_cat);
      if (done_po) n_done++;
    end
  end

  task automatic do_load(input int v, input bit b);
    value_pi = 8'(v);
    blank_en_pi = b;
    load_pi = 1'b1;
    @(negedge clk_pi);
    load_pi = 1'b0;
  endtask

  task automatic slot(input int s, input logic [6:0] cat, input string nm);
    for (int i = 0; i < 200 && out_idx != s; i++) @(negedge clk_pi);
    check({nm, "_slot"}, 32'(out_idx), 32'(s));
    check({nm, "_anode"}, anode_po, (cat == 7'h7f) ? 3'b111 : 3'b111 ^ (3'b001 << s));
    check({nm, "_cathode"}, cathode_po, cat);
  endtask

  typedef struct {
    int         v;
    bit         b;
    logic [6:0] c0, c1, c2;
  } vec_t;
  vec_t vt [8];

  initial begin
    int nb, nd, d0;
    bit b;
    vt[0] = '{255, 1'b0, 7'b0010010, 7'b0010010, 7'b0100100};
    vt[1] = '{7,   1'b1, 7'b1111000, 7'h7f,      7'h7f};
    vt[2] = '{100, 1'b1, 7'b1000000, 7'b1000000, 7'b1111001};
    vt[3] = '{42,  1'b0, 7'b0100100, 7'b0011001, 7'b1000000};
    vt[4] = '{5,   1'b0, 7'b0010010, 7'b1000000, 7'b1000000};
    vt[5] = '{10,  1'b1, 7'b1000000, 7'b1111001, 7'h7f};
    vt[6] = '{0,   1'b1, 7'b1000000, 7'h7f,      7'h7f};
    vt[7] = '{209, 1'b1, 7'b0010000, 7'b1000000, 7'b0100100};

    @(negedge clk_pi);
    @(negedge clk_pi);
    mon_en = 1;
    check("rst_anode", anode_po, 3'b111);
    check("rst_cathode", cathode_po, 7'h7f);
    check("rst_busy", busy_po, 1'b0);
    check("rst_done", done_po, 1'b0);
    rst_pi = 1'b1;

    @(negedge clk_pi);
    check("scan_units_an", anode_po, 3'b110);
    check("scan_units_cat", cathode_po, 7'b1000000);
    repeat (DWELL) @(negedge clk_pi);
    check("scan_tens_an", anode_po, 3'b101);
    check("scan_tens_cat", cathode_po, 7'b1000000);
    repeat (DWELL) @(negedge clk_pi);
    check("scan_hund_an", anode_po, 3'b011);
    check("scan_hund_cat", cathode_po, 7'b1000000);
    repeat (DWELL) @(negedge clk_pi);
    check("scan_wrap_an", anode_po, 3'b110);
    check("scan_wrap_cat", cathode_po, 7'b1000000);

    for (int i = 0; i < 8; i++) begin
      do_load(vt[i].v, vt[i].b);
      nb = int'(busy_po);
      nd = 0;
      repeat (13) begin
        @(negedge clk_pi);
        nb += int'(busy_po);
        nd += int'(done_po);
      end
      check("tab_busy_cycles", 32'(nb), 32'd9);
      check("tab_done_pulses", 32'(nd), 32'd1);
      slot(0, vt[i].c0, "tab_units");
      slot(1, vt[i].c1, "tab_tens");
      slot(2, vt[i].c2, "tab_hund");
    end

    d0 = n_done;
    do_load(42, 1'b0);
    repeat (2) @(negedge clk_pi);
    value_pi = 8'd99;
    load_pi = 1'b1;
    @(negedge clk_pi);
    load_pi = 1'b0;
    repeat (14) @(negedge clk_pi);
    check("ignore_one_done", 32'(n_done - d0), 32'd1);
    slot(0, 7'b0100100, "ignore_units");
    slot(1, 7'b0011001, "ignore_tens");
    slot(2, 7'b1000000, "ignore_hund");

    d0 = n_done;
    do_load(200, 1'b0);
    repeat (3) @(negedge clk_pi);
    rst_pi = 1'b0;
    @(negedge clk_pi);
    check("abort_busy", busy_po, 1'b0);
    check("abort_done", done_po, 1'b0);
    check("abort_anode", anode_po, 3'b111);
    check("abort_cathode", cathode_po, 7'h7f);
    rst_pi = 1'b1;
    @(negedge clk_pi);
    check("abort_restart_an", anode_po, 3'b110);
    repeat (20) @(negedge clk_pi);
    check("abort_no_done", 32'(n_done - d0), 32'd0);
    slot(0, 7'b1000000, "abort_units");
    slot(1, 7'b1000000, "abort_tens");
    slot(2, 7'b1000000, "abort_hund");

    for (int v = 0; v < 256; v++) begin
      b = 1'($urandom_range(0, 1));
      do_load(v, b);
      repeat (6) begin
        load_pi = 1'($urandom_range(0, 1));
        value_pi = 8'($urandom);
        @(negedge clk_pi);
      end
      load_pi = 1'b0;
      for (int i = 0; i < 40 && !done_po; i++) @(negedge clk_pi);
      check("sweep_done", done_po, 1'b1);
      repeat (2) @(negedge clk_pi);
      for (int s = 0; s < 3; s++)
        slot(s, blanked(v, s, b) ? 7'h7f : seg_tab[digit(v, s)], "sweep");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got no completion, expected finish before timeout");
    $fatal(1, "watchdog expired");
  end
endmodule
